// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl: two-player tug-of-war round/match controller, stepped by an internal game-tick enable.
// Optional macro TUG_DEADBAND_EN: the rope only moves when one player leads by more than MARGIN.
module tug_match_ctrl #(
    parameter int W         = 12,
    parameter int TRACK     = 15,
    parameter int TICK_DIV  = 8388608,
    parameter int COUNTDOWN = 3,
    parameter int MARGIN    = 16,
    parameter int WINS      = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [W-1:0]                     p1data,
    input  logic [W-1:0]                     p2data,
    output logic [2:0]                       phase,
    output logic [$clog2(COUNTDOWN+1)-1:0]   count,
    output logic [$clog2(TRACK)-1:0]         pos,
    output logic [1:0]                       winner,
    output logic [$clog2(WINS+1)-1:0]        p1_score,
    output logic [$clog2(WINS+1)-1:0]        p2_score,
    output logic                             tick
);

    localparam int TDW = $clog2(TICK_DIV);
    localparam int CW  = $clog2(COUNTDOWN + 1);
    localparam int PW  = $clog2(TRACK);
    localparam int SW  = $clog2(WINS + 1);

    localparam logic [TDW-1:0] TICK_LAST = TDW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  CSTART    = CW'(COUNTDOWN);
    localparam logic [PW-1:0]  CENTER    = PW'((TRACK - 1) / 2);
    localparam logic [PW-1:0]  LAST      = PW'(TRACK - 1);
    localparam logic [SW-1:0]  SMAX      = SW'(WINS);

    generate
        if (TRACK < 5 || (TRACK % 2) == 0 || TICK_DIV < 2 || COUNTDOWN < 1 ||
            WINS < 1 || MARGIN < 0) begin : g_bad_params
            $error("tug_match_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNT     = 3'd1,
        ST_GO        = 3'd2,
        ST_PLAY      = 3'd3,
        ST_ROUND_END = 3'd4,
        ST_MATCH_END = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [TDW-1:0]  tick_cnt;
    logic            start_pend;
    logic            go;
    logic [CW-1:0]   count_q, count_n;
    logic [PW-1:0]   pos_q, pos_n;
    logic [1:0]      winner_q, winner_n;
    logic [SW-1:0]   s1_q, s1_n, s2_q, s2_n;
    logic            step_up, step_dn;
    logic            match_won;

    assign tick     = (tick_cnt == TICK_LAST);
    assign go       = start_pend | start;
    assign phase    = state;
    assign count    = count_q;
    assign pos      = pos_q;
    assign winner   = winner_q;
    assign p1_score = s1_q;
    assign p2_score = s2_q;

`ifdef TUG_DEADBAND_EN
    localparam logic [W:0] MARG = (W+1)'(MARGIN);
    logic [W:0] p1x, p2x;
    assign p1x     = {1'b0, p1data};
    assign p2x     = {1'b0, p2data};
    assign step_up = p1x > (p2x + MARG);
    assign step_dn = p2x > (p1x + MARG);
`else
    // A tie pulls toward player 2.
    assign step_up = p1data > p2data;
    assign step_dn = ~step_up;
`endif

    assign match_won = (winner_q == 2'd1) ? (s1_q == SMAX) : (s2_q == SMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            start_pend <= 1'b0;
        end else begin
            tick_cnt   <= tick ? '0 : tick_cnt + TDW'(1);
            // Every tick consumes (or discards) the pending request, including a same-cycle start.
            start_pend <= tick ? 1'b0 : (start_pend | start);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count_q  <= '0;
            pos_q    <= CENTER;
            winner_q <= 2'd0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            state    <= state_n;
            count_q  <= count_n;
            pos_q    <= pos_n;
            winner_q <= winner_n;
            s1_q     <= s1_n;
            s2_q     <= s2_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count_q;
        pos_n    = pos_q;
        winner_n = winner_q;
        s1_n     = s1_q;
        s2_n     = s2_q;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    pos_n = CENTER;
                    if (go) begin
                        state_n = ST_COUNT;
                        count_n = CSTART;
                    end
                end
                ST_COUNT: begin
                    if (count_q <= CW'(1)) begin
                        state_n = ST_GO;
                        count_n = '0;
                    end else begin
                        count_n = count_q - CW'(1);
                    end
                end
                ST_GO: state_n = ST_PLAY;
                ST_PLAY: begin
                    if (step_up && pos_q != LAST) begin
                        pos_n = pos_q + PW'(1);
                    end else if (step_dn && pos_q != '0) begin
                        pos_n = pos_q - PW'(1);
                    end
                    if (pos_n == LAST) begin
                        if (s1_q != SMAX) s1_n = s1_q + SW'(1);
                        winner_n = 2'd1;
                        state_n  = ST_ROUND_END;
                    end else if (pos_n == '0) begin
                        if (s2_q != SMAX) s2_n = s2_q + SW'(1);
                        winner_n = 2'd2;
                        state_n  = ST_ROUND_END;
                    end
                end
                ST_ROUND_END: begin
                    if (match_won) begin
                        state_n = ST_MATCH_END;
                    end else if (go) begin
                        pos_n    = CENTER;
                        winner_n = 2'd0;
                        count_n  = CSTART;
                        state_n  = ST_COUNT;
                    end
                end
                ST_MATCH_END: begin
                    if (go) begin
                        s1_n     = '0;
                        s2_n     = '0;
                        pos_n    = CENTER;
                        winner_n = 2'd0;
                        count_n  = CSTART;
                        state_n  = ST_COUNT;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Self-checking bench for tug_match_ctrl: behavioural match model checked every cycle plus directed literals.
module tb_tug_match_ctrl;

    localparam int W = 12, TRACK = 7, TICK_DIV = 4, COUNTDOWN = 3, MARGIN = 16, WINS = 2;
    localparam int C = (TRACK - 1) / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  p1data, p2data;
    logic [2:0]    phase;
    logic [1:0]    count;
    logic [2:0]    pos;
    logic [1:0]    winner;
    logic [1:0]    p1_score, p2_score;
    logic          tick;

    always #5 clk = ~clk;

    tug_match_ctrl #(
        .W(W), .TRACK(TRACK), .TICK_DIV(TICK_DIV),
        .COUNTDOWN(COUNTDOWN), .MARGIN(MARGIN), .WINS(WINS)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1data(p1data), .p2data(p2data),
        .phase(phase), .count(count), .pos(pos), .winner(winner),
        .p1_score(p1_score), .p2_score(p2_score), .tick(tick)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Match model: phases 0 IDLE,1 COUNT,2 GO,3 PLAY,4 ROUND_END,5 MATCH_END.
    int m_cnt, m_phase, m_count, m_pos, m_win, m_s1, m_s2;
    bit m_pend, m_tk, m_go;

    function automatic int move_dir(input int a, input int b);
`ifdef TUG_DEADBAND_EN
        if (a - b > MARGIN) return 1;
        if (b - a > MARGIN) return -1;
        return 0;
`else
        return (a > b) ? 1 : -1;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_pend = 0; m_phase = 0; m_count = 0;
            m_pos = C; m_win = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            m_tk  = (m_cnt == TICK_DIV - 1);
            m_go  = m_pend || (start === 1'b1);
            m_cnt = (m_cnt + 1) % TICK_DIV;
            if (!m_tk) begin
                m_pend = m_go;
            end else begin
                m_pend = 0;
                case (m_phase)
                    0: if (m_go) begin m_phase = 1; m_count = COUNTDOWN; end
                    1: begin
                        m_count = m_count - 1;
                        if (m_count == 0) m_phase = 2;
                    end
                    2: m_phase = 3;
                    3: begin
                        m_pos = m_pos + move_dir(int'(p1data), int'(p2data));
                        if (m_pos == TRACK - 1) begin m_s1++; m_win = 1; m_phase = 4; end
                        else if (m_pos == 0)    begin m_s2++; m_win = 2; m_phase = 4; end
                    end
                    4: begin
                        if (((m_win == 1) ? m_s1 : m_s2) == WINS) m_phase = 5;
                        else if (m_go) begin m_pos = C; m_win = 0; m_phase = 1; m_count = COUNTDOWN; end
                    end
                    5: if (m_go) begin
                        m_s1 = 0; m_s2 = 0; m_win = 0; m_pos = C; m_phase = 1; m_count = COUNTDOWN;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("m_phase",  phase,    m_phase);
            chk("m_count",  count,    m_count);
            chk("m_pos",    pos,      m_pos);
            chk("m_winner", winner,   m_win);
            chk("m_p1s",    p1_score, m_s1);
            chk("m_p2s",    p2_score, m_s2);
            chk("m_tick",   tick,     (m_cnt == TICK_DIV - 1));
        end
    end

    // Advance to the negedge just after the next tick's update.
    task automatic after_tick();
        int n = 0;
        while (m_cnt != TICK_DIV - 1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) chk("tick_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; p1data = '0; p2data = '0; reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i <= 20; i++) begin
            chk("idle_tick", tick, (i % 4 == 0));
            @(negedge clk);
        end
        chk("idle_phase", phase, 0);
        chk("idle_pos", pos, 3);

        // Round 1: p1 pulls hard.
        pulse_start();
        after_tick(); chk("r1_phase_count", phase, 1); chk("r1_count3", count, 3);
        after_tick(); chk("r1_count2", count, 2);
        after_tick(); chk("r1_count1", count, 1);
        p1data = 12'h800; p2data = 12'h100;
        after_tick(); chk("r1_go", phase, 2); chk("r1_go_count", count, 0);
        after_tick(); chk("r1_play", phase, 3); chk("r1_play_pos", pos, 3);
        after_tick(); chk("r1_pos4", pos, 4);
        after_tick(); chk("r1_pos5", pos, 5);
        after_tick(); chk("r1_pos6", pos, 6);
        chk("r1_winner", winner, 1); chk("r1_p1s", p1_score, 1); chk("r1_end", phase, 4);
        after_tick(); chk("r1_hold", phase, 4);

        // Round 2: equal samples.
        p1data = 12'h400; p2data = 12'h400;
        pulse_start();
        after_tick(); chk("r2_count", phase, 1); chk("r2_pos", pos, 3); chk("r2_win0", winner, 0);
        repeat (4) after_tick();
        chk("r2_play", phase, 3);
`ifdef TUG_DEADBAND_EN
        for (int i = 0; i < 10; i++) begin
            after_tick(); chk("r2_db_hold", pos, 3);
        end
        p2data = 12'h411;
`endif
        after_tick(); chk("r2_pos2", pos, 2);
        after_tick(); chk("r2_pos1", pos, 1);
        after_tick(); chk("r2_pos0", pos, 0);
        chk("r2_winner", winner, 2); chk("r2_p2s", p2_score, 1); chk("r2_end", phase, 4);

        // Round 3: p1 takes the match; a start during COUNT is ignored.
        p1data = 12'h800; p2data = 12'h100;
        pulse_start();
        after_tick(); chk("r3_count3", count, 3);
        pulse_start();
        after_tick(); chk("r3_count2", count, 2);
        repeat (3) after_tick();
        chk("r3_play", phase, 3);
        repeat (3) after_tick();
        chk("r3_end", phase, 4); chk("r3_p1s", p1_score, 2); chk("r3_winner", winner, 1);
        after_tick(); chk("match_end", phase, 5); chk("match_winner", winner, 1); chk("match_p1s", p1_score, 2);
        after_tick(); chk("match_hold", phase, 5);
        pulse_start();
        after_tick();
        chk("rematch_phase", phase, 1); chk("rematch_count", count, 3);
        chk("rematch_p1s", p1_score, 0); chk("rematch_p2s", p2_score, 0); chk("rematch_win", winner, 0);
        repeat (4) after_tick();
        repeat (2) after_tick();
        chk("r4_pos5", pos, 5); chk("r4_play", phase, 3);

        // Asynchronous reset mid-play.
        #2 reset = 1'b1;
        #1;
        chk("rst_phase", phase, 0); chk("rst_count", count, 0); chk("rst_pos", pos, 3);
        chk("rst_win", winner, 0); chk("rst_p1s", p1_score, 0); chk("rst_p2s", p2_score, 0);
        chk("rst_tick", tick, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Start on the tick cycle itself is consumed by that tick.
        for (int n = 0; n < 8 && m_cnt != TICK_DIV - 1; n++) @(negedge clk);
        chk("rst_first_tick", tick, 1);
        pulse_start();
        chk("replay_phase", phase, 1); chk("replay_count", count, 3);
        after_tick(); chk("replay_count2", count, 2);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tug_match_ctrl.md
# tug_match_ctrl

Parametrised two-player tug-of-war match controller. It sits between the two ADC sample channels and the LED-matrix screen decoder. It runs a countdown, steps a rope position one place per game tick toward the stronger player, and declares a round winner at either end of the track. It also keeps a best-of-N match score. The tick is a synchronous clock enable, not a derived clock, so all logic runs on `clk`.

## Interface
Parameters:
- `W`, 12: ADC sample width.
- `TRACK`, 15: number of rope positions, 0..TRACK-1. Must be odd and ≥ 5.
- `TICK_DIV`, 8388608: `clk` cycles per game tick. Must be ≥ 2.
- `COUNTDOWN`, 3: first countdown value shown.
- `MARGIN`, 16: deadband in ADC LSBs. Used only with `TUG_DEADBAND_EN`.
- `WINS`, 2: round wins needed to take the match.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle request to begin or continue.
- `p1data` in W: player 1 sample.
- `p2data` in W: player 2 sample.
- `phase` out 3: 0 IDLE, 1 COUNT, 2 GO, 3 PLAY, 4 ROUND_END, 5 MATCH_END.
- `count` out $clog2(COUNTDOWN+1): current countdown value; 0 outside COUNT.
- `pos` out $clog2(TRACK): rope position. 0 is the player-2 end, TRACK-1 is the player-1 end.
- `winner` out 2: 0 none, 1 p1, 2 p2. Refers to the last round in ROUND_END and to the match in MATCH_END.
- `p1_score`, `p2_score` out $clog2(WINS+1) each: rounds won.
- `tick` out 1: one-cycle pulse on each game tick.

## Operation
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick` is 1 in the cycle the counter equals TICK_DIV-1.
  - Free-running from reset.
- `start_pend`:
  - Set by `start`.
  - Cleared in the tick cycle that consumes it.
  - A `start` in the same cycle as a consuming tick is consumed immediately.
  - Multiple starts between ticks collapse to one.
- Every state transition and update of `pos`, `count` and the scores happens only in a cycle with `tick`=1.
- FSM, one step per tick:
  - IDLE: pos=C, where C=(TRACK-1)/2. On start_pend: go to COUNT with count=COUNTDOWN.
  - COUNT: count decrements each tick. When count=1: next is GO and count becomes 0.
  - GO: lasts exactly one tick, then PLAY.
  - PLAY: move rule, see below.
    - pos reaching TRACK-1: p1_score++, winner=1, go to ROUND_END.
    - pos reaching 0: p2_score++, winner=2, same.
    - Scores update on the same tick pos reaches the end.
  - ROUND_END, winner's score = WINS: next tick goes to MATCH_END. winner is kept.
  - ROUND_END, otherwise: on start_pend, pos=C, winner=0, go to COUNT.
  - MATCH_END: on start_pend, clear scores, winner=0, pos=C, go to COUNT.
- Move rule in PLAY, without the deadband macro:
  - p1data > p2data: pos+1.
  - Otherwise: pos-1. A tie favours player 2.
- Samples are compared combinationally in the tick cycle; there is no extra sampling latency.
- Scores never exceed WINS. pos never leaves 0..TRACK-1.
- `start` outside IDLE, ROUND_END and MATCH_END is ignored, and `start_pend` is cleared on the next tick.

## Timing
- Reset values:
  - phase=0 (IDLE), count=0, pos=C, winner=0, scores=0, tick=0.
  - Tick counter=0 and start_pend=0.
- Reset is asynchronous and may arrive mid-round. All outputs return to their reset values immediately.
- First `tick` comes TICK_DIV cycles after reset deasserts, and then every TICK_DIV cycles.
- Outputs change on the clock edge that ends the tick cycle, so they are registered with 1-cycle latency from `tick`.
- From start_pend in IDLE to the first PLAY move: COUNTDOWN ticks of COUNT, then 1 tick of GO, then the move on the next tick, for COUNTDOWN+2 ticks in total.
- Fastest round win from PLAY entry: C ticks.

## Configuration
- `TUG_DEADBAND_EN`, defined:
  - PLAY moves pos+1 only if p1data > p2data + MARGIN.
  - It moves pos-1 only if p2data > p1data + MARGIN.
  - Otherwise pos holds.
  - Sums are computed at W+1 bits so they cannot overflow.
- Not defined: the strict rule above applies, with ties moving toward player 2 and MARGIN unused.

## Test plan
Bench parameters: W=12, TRACK=7 (C=3), TICK_DIV=4, COUNTDOWN=3, MARGIN=16, WINS=2.
- Reset, then idle 20 cycles -> phase=0, pos=3, tick pulses at cycles 4, 8, 12, 16, 20.
- `start` pulse at cycle 1 -> count=3, 2, 1 on successive ticks, then GO for one tick, then PLAY.
- PLAY with p1=0x800, p2=0x100 -> pos 4, 5, 6 on consecutive ticks. On the pos=6 tick: winner=1, p1_score=1, phase=ROUND_END.
- Second round with p1=p2=0x400, macro off -> pos 2, 1, 0 and p2_score=1. Macro on -> pos stays 3 for 10 ticks. Macro on with p2=p1+17 -> pos decrements.
- p1 wins two rounds -> ROUND_END, then MATCH_END on the next tick with winner=1, p1_score=2. A further `start` clears the scores and enters COUNT.
- Assert `reset` mid-PLAY at pos=5 -> all outputs take their reset values in the same cycle, and a later `start` replays the countdown from 3.
